// File: rtl/round_controller_if.sv
// Player/timer-facing signal bundle of the round controller.
interface round_controller_if;
  logic       start_btn;
  logic       submit_btn;
  logic [7:0] answer;
  logic [7:0] timer_value;
  logic       restart_timer;
  logic [7:0] target;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       result_ok;
  logic       result_bad;

  // Environment side: buttons, switches and timer drive the controller.
  modport master (
    output start_btn, submit_btn, answer, timer_value,
    input  restart_timer, target, score, lives, state, result_ok, result_bad
  );

  // Controller side.
  modport slave (
    input  start_btn, submit_btn, answer, timer_value,
    output restart_timer, target, score, lives, state, result_ok, result_bad
  );
endinterface

// File: rtl/round_controller.sv
// Quiz-game round sequencer: picks a pseudo-random target, times the answer
// window, tracks score and lives, and pulses the external timer restart.
module round_controller #(
  parameter logic [7:0] TIME_LIMIT    = 8'd10,
  parameter logic [7:0] FEEDBACK_TIME = 8'd2,
  parameter logic [1:0] START_LIVES   = 2'd3
) (
  input logic               clk,
  input logic               rst,
  round_controller_if.slave game_if
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_NEW_ROUND = 3'd1,
    S_PLAY      = 3'd2,
    S_CORRECT   = 3'd3,
    S_WRONG     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       start_prev_q, submit_prev_q;
  logic [7:0] target_q, target_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       restart_q, restart_d;
  logic       ok_q, ok_d;
  logic       bad_q, bad_d;
  logic       start_edge, submit_edge;
  logic       timed_out, feedback_done;

  assign start_edge    = game_if.start_btn  & ~start_prev_q;
  assign submit_edge   = game_if.submit_btn & ~submit_prev_q;
  assign timed_out     = game_if.timer_value >= TIME_LIMIT;
  // restart_q is high exactly in the first feedback cycle, when timer_value
  // still reflects the previous round, so it doubles as the exit mask.
  assign feedback_done = ~restart_q & (game_if.timer_value >= FEEDBACK_TIME);

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    lives_d  = lives_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_edge) begin
          score_d = 8'd0;
          lives_d = START_LIVES;
          state_d = S_NEW_ROUND;
        end
      end
      S_NEW_ROUND: begin
        target_d = lfsr_q;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        if (submit_edge && (game_if.answer == target_q)) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_d = S_CORRECT;
        end else if (submit_edge || timed_out) begin
          lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
          state_d = S_WRONG;
        end
      end
      S_CORRECT: begin
        if (feedback_done) state_d = S_NEW_ROUND;
      end
      S_WRONG: begin
        if (feedback_done) state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_NEW_ROUND;
      end
      default: state_d = S_IDLE;
    endcase
    restart_d = (state_d != state_q) &&
                ((state_d == S_NEW_ROUND) || (state_d == S_CORRECT) || (state_d == S_WRONG));
    ok_d      = (state_d == S_CORRECT);
    bad_d     = (state_d == S_WRONG);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 8'h5A;
      start_prev_q  <= 1'b1;
      submit_prev_q <= 1'b1;
      target_q      <= 8'd0;
      score_q       <= 8'd0;
      lives_q       <= 2'd0;
      restart_q     <= 1'b0;
      ok_q          <= 1'b0;
      bad_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      start_prev_q  <= game_if.start_btn;
      submit_prev_q <= game_if.submit_btn;
      target_q      <= target_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      restart_q     <= restart_d;
      ok_q          <= ok_d;
      bad_q         <= bad_d;
    end
  end

  assign game_if.state         = 3'(state_q);
  assign game_if.target        = target_q;
  assign game_if.score         = score_q;
  assign game_if.lives         = lives_q;
  assign game_if.restart_timer = restart_q;
  assign game_if.result_ok     = ok_q;
  assign game_if.result_bad    = bad_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed vector table, long
// saturation sequence and randomized stimulus against a behavioural model.
module tb_round_controller;

  localparam logic [7:0] TL = 8'd10;
  localparam logic [7:0] FB = 8'd2;
  localparam int         SL = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  round_controller_if bus ();

  round_controller #(
    .TIME_LIMIT   (TL),
    .FEEDBACK_TIME(FB),
    .START_LIVES  (2'(SL))
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .game_if(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: game state as plain numbers, plus time spent in the
  // current state (m_age counts cycles already spent there).
  int         m_state, m_age, m_score, m_lives;
  logic [7:0] m_target, m_lfsr;
  bit         m_pst, m_psb, m_rt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit se, be;
    int ns;
    se = bus.start_btn  && !m_pst;
    be = bus.submit_btn && !m_psb;
    if (rst) begin
      m_state = 0; m_age = 0; m_target = 8'd0; m_score = 0; m_lives = 0;
      m_lfsr = 8'h5A; m_pst = 1'b1; m_psb = 1'b1; m_rt = 1'b0;
      return;
    end
    ns = m_state;
    case (m_state)
      0, 5: if (se) begin m_score = 0; m_lives = SL; ns = 1; end
      1: begin m_target = m_lfsr; ns = 2; end
      2: begin
        if (be && bus.answer == m_target) begin
          if (m_score < 255) m_score++;
          ns = 3;
        end else if (be || bus.timer_value >= TL) begin
          if (m_lives > 0) m_lives--;
          ns = 4;
        end
      end
      3, 4: if (m_age >= 1 && bus.timer_value >= FB)
              ns = (m_state == 4 && m_lives == 0) ? 5 : 1;
      default: ns = 0;
    endcase
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_pst  = bus.start_btn;
    m_psb  = bus.submit_btn;
    m_rt   = (ns != m_state) && (ns == 1 || ns == 3 || ns == 4);
    m_age  = (ns == m_state) ? m_age + 1 : 0;
    m_state = ns;
  endtask

  // One clock: model follows the edge, outputs compared 2 time units later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
    chk("state",   int'(bus.state),         m_state);
    chk("target",  int'(bus.target),        int'(m_target));
    chk("score",   int'(bus.score),         m_score);
    chk("lives",   int'(bus.lives),         m_lives);
    chk("restart", int'(bus.restart_timer), int'(m_rt));
    chk("ok",      int'(bus.result_ok),     int'(m_state == 3));
    chk("bad",     int'(bus.result_bad),    int'(m_state == 4));
  endtask

  task automatic correct_round();
    int n = 0;
    rst = 1'b0; bus.start_btn = 1'b0; bus.submit_btn = 1'b0; bus.timer_value = 8'd0;
    while (m_state != 2 && n < 8) begin cycle(); n++; end
    chk("round_reach_play", m_state, 2);
    bus.submit_btn = 1'b1; bus.answer = m_target;
    cycle();
    bus.submit_btn = 1'b0; bus.timer_value = 8'd2;
    cycle();
    cycle();
  endtask

  typedef struct {
    bit         rst;
    bit         start;
    bit         submit;
    bit         wrong;
    logic [7:0] timer;
    int         exp_state;
    int         exp_score;
    int         exp_lives;
    bit         exp_rt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    bus.start_btn = 1'b0; bus.submit_btn = 1'b0;
    bus.answer = 8'd0; bus.timer_value = 8'd0;
    m_state = 0; m_age = 0; m_score = 0; m_lives = 0;
    m_target = 8'd0; m_lfsr = 8'h5A; m_pst = 1'b1; m_psb = 1'b1; m_rt = 1'b0;

    //            rst st  sub wr  timer  state score lives rt
    tbl.push_back('{1, 0, 0, 0, 8'd0,  0, 0, 0, 0});  // reset
    tbl.push_back('{0, 0, 0, 0, 8'd0,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'd0,  1, 0, 3, 1});  // start edge
    tbl.push_back('{0, 1, 0, 0, 8'd0,  2, 0, 3, 0});  // held start: no edge
    tbl.push_back('{0, 0, 1, 0, 8'd0,  3, 1, 3, 1});  // correct answer
    tbl.push_back('{0, 0, 0, 0, 8'd50, 3, 1, 3, 0});  // stale timer masked
    tbl.push_back('{0, 0, 0, 0, 8'd0,  3, 1, 3, 0});
    tbl.push_back('{0, 0, 0, 0, 8'd2,  1, 1, 3, 1});  // feedback done
    tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 1, 3, 0});
    tbl.push_back('{0, 0, 0, 0, 8'd10, 4, 1, 2, 1});  // timeout
    tbl.push_back('{0, 0, 0, 0, 8'd2,  4, 1, 2, 0});  // masked first cycle
    tbl.push_back('{0, 0, 0, 0, 8'd2,  1, 1, 2, 1});
    tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 1, 2, 0});
    tbl.push_back('{0, 0, 1, 0, 8'd10, 3, 2, 2, 1});  // submit beats timeout
    tbl.push_back('{0, 0, 0, 0, 8'd0,  3, 2, 2, 0});
    tbl.push_back('{0, 0, 0, 0, 8'd2,  1, 2, 2, 1});
    tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 2, 2, 0});
    tbl.push_back('{0, 0, 1, 1, 8'd0,  4, 2, 1, 1});  // wrong answer
    tbl.push_back('{0, 0, 0, 0, 8'd2,  4, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 8'd2,  1, 2, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 2, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 8'd0,  4, 2, 0, 1});  // last life lost
    tbl.push_back('{0, 0, 0, 0, 8'd2,  4, 2, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 8'd2,  5, 2, 0, 0});  // game over
    tbl.push_back('{0, 0, 1, 0, 8'd0,  5, 2, 0, 0});  // submit ignored
    tbl.push_back('{0, 0, 0, 0, 8'd0,  5, 2, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'd0,  1, 0, 3, 1});  // restart game
    tbl.push_back('{0, 0, 0, 0, 8'd0,  2, 0, 3, 0});
    tbl.push_back('{1, 1, 0, 0, 8'd0,  0, 0, 0, 0});  // reset mid-round
    tbl.push_back('{0, 1, 0, 0, 8'd0,  0, 0, 0, 0});  // start held through release
    tbl.push_back('{0, 1, 0, 0, 8'd0,  0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 8'd0,  0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'd0,  1, 0, 3, 1});

    foreach (tbl[i]) begin
      rst             = tbl[i].rst;
      bus.start_btn   = tbl[i].start;
      bus.submit_btn  = tbl[i].submit;
      bus.timer_value = tbl[i].timer;
      bus.answer      = tbl[i].wrong ? (m_target ^ 8'h01) : m_target;
      cycle();
      chk($sformatf("vec%0d_state", i), int'(bus.state),         tbl[i].exp_state);
      chk($sformatf("vec%0d_score", i), int'(bus.score),         tbl[i].exp_score);
      chk($sformatf("vec%0d_lives", i), int'(bus.lives),         tbl[i].exp_lives);
      chk($sformatf("vec%0d_rt", i),    int'(bus.restart_timer), int'(tbl[i].exp_rt));
    end

    // Score saturation: 255 correct rounds, then one more.
    for (int r = 0; r < 255; r++) correct_round();
    chk("score_at_255", int'(bus.score), 255);
    correct_round();
    chk("score_saturated", int'(bus.score), 255);
    chk("lives_after_sat", int'(bus.lives), SL);

    // Randomized play against the model.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) bus.start_btn = ~bus.start_btn;
      if ($urandom_range(0, 2) == 0) bus.submit_btn = ~bus.submit_btn;
      bus.answer      = ($urandom_range(0, 1) == 0) ? m_target : 8'($urandom);
      bus.timer_value = 8'($urandom_range(0, 12));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
